// File: rtl/led_blink_if.sv
// Command channel of the LED sequencer: valid/ready handshake, command fields and abort.
interface led_blink_if #(
  parameter int CNT_W   = 29,
  parameter int BURST_W = 8
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_mode;
  logic [CNT_W-1:0]   cmd_on_ticks;
  logic [CNT_W-1:0]   cmd_off_ticks;
  logic [BURST_W-1:0] cmd_pulses;
  logic               abort;

  modport master (
    output cmd_valid, cmd_mode, cmd_on_ticks, cmd_off_ticks, cmd_pulses, abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_on_ticks, cmd_off_ticks, cmd_pulses, abort,
    output cmd_ready
  );
endinterface

// File: rtl/led_blink_ctrl.sv
// Programmable LED sequencer: OFF / SOLID / BLINK / N-pulse BURST with
// cycle-accurate on/off phase lengths and an exposed phase counter.
module led_blink_ctrl #(
  parameter int CNT_W   = 29,
  parameter int BURST_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  led_blink_if.slave       cmd,
  output logic             led,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {M_OFF, M_SOLID, M_BLINK, M_BURST} mode_e;
  typedef enum logic [1:0] {IDLE, SOLID, ON_PH, OFF_PH} state_e;

  state_e             state;
  mode_e              mode_q;
  mode_e              cmd_mode;
  logic [CNT_W-1:0]   on_q, off_q;
  logic [BURST_W-1:0] remaining;
  logic [CNT_W-1:0]   on_last, off_last;
  logic               in_phase;
  logic               accept;

  assign cmd_mode = mode_e'(cmd.cmd_mode);
  assign in_phase = (state == ON_PH) || (state == OFF_PH);

  // A running BURST cannot be preempted; abort also blocks acceptance.
  assign cmd.cmd_ready = !cmd.abort && !(in_phase && mode_q == M_BURST);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign busy          = (state != IDLE);

  // Zero-length phases behave as one cycle.
  assign on_last  = (on_q  == '0) ? '0 : on_q  - 1'b1;
  assign off_last = (off_q == '0) ? '0 : off_q - 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= M_OFF;
      on_q      <= '0;
      off_q     <= '0;
      remaining <= '0;
      led       <= 1'b0;
      count     <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cmd.abort) begin
        state <= IDLE;
        led   <= 1'b0;
        count <= '0;
      end else if (accept) begin
        mode_q    <= cmd_mode;
        on_q      <= cmd.cmd_on_ticks;
        off_q     <= cmd.cmd_off_ticks;
        remaining <= cmd.cmd_pulses;
        count     <= '0;
        case (cmd_mode)
          M_OFF: begin
            state <= IDLE;
            led   <= 1'b0;
          end
          M_SOLID: begin
            state <= SOLID;
            led   <= 1'b1;
          end
          M_BLINK: begin
            state <= ON_PH;
            led   <= 1'b1;
          end
          default: begin
            if (cmd.cmd_pulses == '0) begin
              state <= IDLE;
              led   <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= ON_PH;
              led   <= 1'b1;
            end
          end
        endcase
      end else begin
        case (state)
          ON_PH: begin
            if (count == on_last) begin
              state <= OFF_PH;
              count <= '0;
              led   <= 1'b0;
            end else begin
              count <= count + 1'b1;
            end
          end
          OFF_PH: begin
            if (count == off_last) begin
              count <= '0;
              if (mode_q == M_BLINK) begin
                state <= ON_PH;
                led   <= 1'b1;
              end else if (remaining > 1) begin
                remaining <= remaining - 1'b1;
                state     <= ON_PH;
                led       <= 1'b1;
              end else begin
                remaining <= '0;
                state     <= IDLE;
                led       <= 1'b0;
                done      <= 1'b1;
              end
            end else begin
              count <= count + 1'b1;
            end
          end
          default: begin
            count <= '0;
          end
        endcase
      end
    end
  end

endmodule
